// File: rtl/shift_chain_driver_pkg.sv
// Shared definitions for the shift-chain driver: FSM state encoding and a
// constant-evaluable ceiling log2 used to size the counters.
package shift_chain_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_chain_driver_sclk_divider.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles,
// restarted from zero by clear.
module sclk_divider
    import shift_chain_driver_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = clog2(CLK_DIV) + 1;

    logic [W-1:0] cnt;

    assign tick = enable && !clear && (cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_chain_driver.sv
// Parallel-in/serial-out driver for a daisy chain of 8-bit latching shift
// registers: captures a word on start/ready, shifts it on sdo/sclk, then latches.
module shift_chain_driver
    import shift_chain_driver_pkg::*;
#(
    parameter int N_BYTES    = 2,
    parameter int CLK_DIV    = 4,
    parameter int BYTE_ORDER = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_BYTES-1:0] data,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic                 sdo,
    output logic                 sclk,
    output logic                 latch
);

    localparam int NBITS = 8 * N_BYTES;
    localparam int BW    = clog2(NBITS) + 1;

    state_t           state, state_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [NBITS-1:0] sreg, sreg_n;
    logic [NBITS-1:0] ordered;
    logic             sclk_n, done_n;
    logic             tick;

    // Pure wiring: position p of the outgoing stream lands at ordered[NBITS-1-p].
    for (genvar p = 0; p < NBITS; p++) begin : g_order
        localparam int SB = (BYTE_ORDER != 0) ? (N_BYTES - 1 - p / 8) : (p / 8);
        localparam int SI = (MSB_FIRST != 0) ? (7 - p % 8) : (p % 8);
        assign ordered[NBITS-1-p] = data[SB*8+SI];
    end

    sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_IDLE),
        .enable (state != ST_IDLE),
        .tick   (tick)
    );

    assign sdo = sreg[NBITS-1];

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sreg_n    = sreg;
        sclk_n    = sclk;
        done_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                bit_cnt_n = '0;
                if (start) begin
                    state_n = ST_SHIFT;
                    sreg_n  = ordered;
                    sclk_n  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        // Last bit keeps sdo where it is through the latch phase.
                        if (bit_cnt == BW'(NBITS - 1)) begin
                            state_n   = ST_LATCH;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                            sreg_n    = {sreg[NBITS-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
            sclk    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            latch   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            sreg    <= sreg_n;
            sclk    <= sclk_n;
            done    <= done_n;
            ready   <= (state_n == ST_IDLE);
            latch   <= (state_n == ST_LATCH);
        end
    end

endmodule

// File: tb/tb_shift_chain_driver.sv
// Directed bench for shift_chain_driver: three instances cover the default
// ordering, reversed byte/LSB-first ordering, and a slower 3-byte chain.
module tb_shift_chain_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] data_a = '0, data_b = '0;
    logic [23:0] data_c = '0;
    logic start_a = 0, start_b = 0, start_c = 0;
    logic ready_a, done_a, sdo_a, sclk_a, latch_a;
    logic ready_b, done_b, sdo_b, sclk_b, latch_b;
    logic ready_c, done_c, sdo_c, sclk_c, latch_c;

    shift_chain_driver #(.N_BYTES(2), .CLK_DIV(1), .BYTE_ORDER(0), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .start(start_a), .ready(ready_a),
        .done(done_a), .sdo(sdo_a), .sclk(sclk_a), .latch(latch_a));

    shift_chain_driver #(.N_BYTES(2), .CLK_DIV(1), .BYTE_ORDER(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .start(start_b), .ready(ready_b),
        .done(done_b), .sdo(sdo_b), .sclk(sclk_b), .latch(latch_b));

    shift_chain_driver #(.N_BYTES(3), .CLK_DIV(4), .BYTE_ORDER(0), .MSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .data(data_c), .start(start_c), .ready(ready_c),
        .done(done_c), .sdo(sdo_c), .sclk(sclk_c), .latch(latch_c));

    int n_cmp = 0;
    int n_err = 0;
    int cur = 0;
    logic o_ready, o_done, o_sdo, o_sclk, o_latch;

    always_comb begin
        o_ready = ready_a; o_done = done_a; o_sdo = sdo_a; o_sclk = sclk_a; o_latch = latch_a;
        case (cur)
            1: begin o_ready = ready_b; o_done = done_b; o_sdo = sdo_b; o_sclk = sclk_b; o_latch = latch_b; end
            2: begin o_ready = ready_c; o_done = done_c; o_sdo = sdo_c; o_sclk = sclk_c; o_latch = latch_c; end
            default: ;
        endcase
    end

    task automatic drive(input int sel, input logic [23:0] d, input logic s);
        case (sel)
            0: begin data_a = d[15:0]; start_a = s; end
            1: begin data_b = d[15:0]; start_b = s; end
            default: begin data_c = d; start_c = s; end
        endcase
    endtask

    // One transfer: seq collects sdo at each sclk rise, first bit ending in the MSB
    // of the low nrise bits. terr counts edges off the expected sclk/sdo schedule.
    task automatic run_xfer(input int sel, input logic [23:0] d, input int div, input bit hold,
                            output logic [23:0] seq, output int nrise, output int done_at,
                            output int latch_cnt, output int terr);
        logic ps, pd;
        seq = '0; nrise = 0; done_at = -1; latch_cnt = 0; terr = 0;
        cur = sel;
        @(negedge clk);
        drive(sel, d, 1'b1);
        @(posedge clk); #1;
        if (!hold) drive(sel, d, 1'b0);
        if (o_ready !== 1'b0 || o_done !== 1'b0 || o_sclk !== 1'b0) terr++;
        ps = o_sclk; pd = o_sdo;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            if (o_sclk && !ps) begin
                seq = {seq[22:0], o_sdo};
                if (cyc != div + 2 * div * nrise) terr++;
                nrise++;
            end
            if (!o_sclk && ps && cyc != 2 * div * nrise) terr++;
            if (o_sdo !== pd && !(ps && !o_sclk)) terr++;
            if (o_latch) latch_cnt++;
            ps = o_sclk; pd = o_sdo;
            if (o_done) begin
                done_at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        cur = 0;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", o_done); end
        n_cmp++; if (o_sdo !== 1'b0) begin n_err++; $display("FAIL reset_sdo: got %b expected 0", o_sdo); end
        n_cmp++; if (o_sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b expected 0", o_sclk); end
        n_cmp++; if (o_latch !== 1'b0) begin n_err++; $display("FAIL reset_latch: got %b expected 0", o_latch); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_order();
        logic [23:0] seq; int nr, da, lc, te;
        run_xfer(0, 24'h00A55A, 1, 1'b0, seq, nr, da, lc, te);
        n_cmp++; if (seq[15:0] !== 16'h5AA5) begin n_err++; $display("FAIL default_bits: got %h expected 5aa5", seq[15:0]); end
        n_cmp++; if (nr != 16) begin n_err++; $display("FAIL default_rises: got %0d expected 16", nr); end
        n_cmp++; if (da != 33) begin n_err++; $display("FAIL default_done_at: got %0d expected 33", da); end
        n_cmp++; if (lc != 1) begin n_err++; $display("FAIL default_latch_len: got %0d expected 1", lc); end
        n_cmp++; if (te != 0) begin n_err++; $display("FAIL default_timing: got %0d errors expected 0", te); end
    endtask

    task automatic test_reversed_order();
        logic [23:0] seq; int nr, da, lc, te;
        run_xfer(1, 24'h008001, 1, 1'b0, seq, nr, da, lc, te);
        n_cmp++; if (seq[15:0] !== 16'h0180) begin n_err++; $display("FAIL reversed_bits: got %h expected 0180", seq[15:0]); end
        n_cmp++; if (da != 33) begin n_err++; $display("FAIL reversed_done_at: got %0d expected 33", da); end
        n_cmp++; if (te != 0) begin n_err++; $display("FAIL reversed_timing: got %0d errors expected 0", te); end
    endtask

    task automatic test_slow_three_byte();
        logic [23:0] seq; int nr, da, lc, te;
        run_xfer(2, 24'h123456, 4, 1'b0, seq, nr, da, lc, te);
        n_cmp++; if (seq !== 24'h563412) begin n_err++; $display("FAIL div4_bits: got %h expected 563412", seq); end
        n_cmp++; if (nr != 24) begin n_err++; $display("FAIL div4_rises: got %0d expected 24", nr); end
        n_cmp++; if (lc != 4) begin n_err++; $display("FAIL div4_latch_len: got %0d expected 4", lc); end
        n_cmp++; if (da != 196) begin n_err++; $display("FAIL div4_done_at: got %0d expected 196", da); end
        n_cmp++; if (te != 0) begin n_err++; $display("FAIL div4_phases: got %0d errors expected 0", te); end
    endtask

    task automatic test_ignored_start();
        logic [23:0] seq; int nr, da, lc, te;
        fork
            run_xfer(0, 24'h00A55A, 1, 1'b0, seq, nr, da, lc, te);
            begin
                repeat (12) @(negedge clk);
                data_a = 16'hFFFF;
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
        join
        n_cmp++; if (seq[15:0] !== 16'h5AA5) begin n_err++; $display("FAIL busy_start_bits: got %h expected 5aa5", seq[15:0]); end
        n_cmp++; if (da != 33) begin n_err++; $display("FAIL busy_start_done_at: got %0d expected 33", da); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL busy_start_not_queued: ready got %b expected 1", ready_a); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [23:0] seq; int nr, da, lc, te; int lat;
        cur = 0;
        @(negedge clk);
        drive(0, 24'h00FFFF, 1'b1);
        @(posedge clk); #1;
        drive(0, 24'h00FFFF, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        n_cmp++; if ({sdo_a, sclk_a} !== 2'b11) begin n_err++; $display("FAIL bit9_before_reset: sdo/sclk got %b expected 11", {sdo_a, sclk_a}); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({ready_a, done_a, sdo_a, sclk_a, latch_a} !== 5'b10000) begin
            n_err++; $display("FAIL async_reset_outputs: rdy/done/sdo/sclk/latch got %b expected 10000",
                              {ready_a, done_a, sdo_a, sclk_a, latch_a});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        lat = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (latch_a || done_a) lat++;
        end
        n_cmp++; if (lat != 0) begin n_err++; $display("FAIL aborted_no_latch: got %0d latch/done cycles expected 0", lat); end
        run_xfer(0, 24'h00A55A, 1, 1'b0, seq, nr, da, lc, te);
        n_cmp++; if (seq[15:0] !== 16'h5AA5) begin n_err++; $display("FAIL post_reset_bits: got %h expected 5aa5", seq[15:0]); end
        n_cmp++; if (da != 33) begin n_err++; $display("FAIL post_reset_done_at: got %0d expected 33", da); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [15:0] chain_q;
        logic [23:0] seq; int nr, da, lc, te;
        words[0] = 16'h1234; words[1] = 16'hC3E1; words[2] = 16'h0F0F;
        for (int w = 0; w < 3; w++) begin
            run_xfer(0, {8'h00, words[w]}, 1, 1'b1, seq, nr, da, lc, te);
            // Chain model: the first bit shifted travels furthest, so with byte 0
            // MSB-first leading, the latched chain reads {byte0, byte1}.
            chain_q = {words[w][7:0], words[w][15:8]};
            n_cmp++; if (seq[15:0] !== chain_q) begin n_err++; $display("FAIL b2b_word%0d_chain: got %h expected %h", w, seq[15:0], chain_q); end
            n_cmp++; if (da != 33) begin n_err++; $display("FAIL b2b_word%0d_done_at: got %0d expected 33", w, da); end
            n_cmp++; if (te != 0) begin n_err++; $display("FAIL b2b_word%0d_no_gap: got %0d errors expected 0", w, te); end
        end
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL b2b_release_idle: ready got %b expected 1", ready_a); end
    endtask

    initial begin
        test_reset();
        test_default_order();
        test_reversed_order();
        test_slow_three_byte();
        test_ignored_start();
        test_reset_mid_transfer();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
